// File: rtl/alu_iterative_exec.sv
// rtl/alu_iterative_exec.sv - execute-stage ALU with single-cycle logic ops and a bit-serial shifter
module alu_iterative_exec #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [3:0]      ALUCtrl_i,
  input  logic [XLEN-1:0] A_i,
  input  logic [XLEN-1:0] B_i,
  input  logic            flush_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] Result_o,
  output logic            Zero_o,
  output logic            busy_o
);

  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SLL = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_LUI = 4'b1000;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic [XLEN-1:0]      result_q;
  logic                 zero_q;
  logic [SHAMT_W-1:0]   count_q;
  logic                 left_q;
  logic                 arith_q;

  logic                 accept;
  logic                 is_shift;
  logic                 is_lui;
  logic [XLEN-1:0]      quick_result;
  logic [XLEN-1:0]      shift_src;
  logic [SHAMT_W-1:0]   shift_count;
  logic [XLEN-1:0]      shifted;

  assign accept      = req_valid_i & (state_q == IDLE) & ~flush_i;
  assign is_lui      = (ALUCtrl_i == OP_LUI);
  assign is_shift    = (ALUCtrl_i == OP_SLL) | (ALUCtrl_i == OP_SRL) |
                       (ALUCtrl_i == OP_SRA) | is_lui;
  assign shift_src   = is_lui ? B_i : A_i;
  assign shift_count = is_lui ? SHAMT_W'(12) : B_i[SHAMT_W-1:0];
  // sra refills from the current MSB so repeated single steps preserve the sign
  assign shifted     = left_q ? {result_q[XLEN-2:0], 1'b0}
                              : {arith_q & result_q[XLEN-1], result_q[XLEN-1:1]};

  // Single-cycle operations; reserved codes fall through to add
  always_comb begin
    quick_result = A_i + B_i;
    case (ALUCtrl_i)
      OP_SUB:  quick_result = A_i - B_i;
      OP_XOR:  quick_result = A_i ^ B_i;
      OP_OR:   quick_result = A_i | B_i;
      OP_AND:  quick_result = A_i & B_i;
      default: quick_result = A_i + B_i;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; flush overrides every other event
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = (is_shift && shift_count != '0) ? SHIFT : DONE;
        SHIFT:   if (count_q == SHAMT_W'(1)) state_d = DONE;
        DONE:    if (res_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Result, zero flag, shift count and latched shift direction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      count_q  <= '0;
      left_q   <= 1'b0;
      arith_q  <= 1'b0;
    end else if (flush_i) begin
      count_q  <= '0;
    end else if (accept) begin
      if (is_shift) begin
        result_q <= shift_src;
        zero_q   <= (shift_src == '0);
        count_q  <= shift_count;
        left_q   <= (ALUCtrl_i == OP_SLL) | is_lui;
        arith_q  <= (ALUCtrl_i == OP_SRA);
      end else begin
        result_q <= quick_result;
        zero_q   <= (quick_result == '0);
      end
    end else if (state_q == SHIFT) begin
      result_q <= shifted;
      zero_q   <= (shifted == '0);
      count_q  <= count_q - SHAMT_W'(1);
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign res_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign Result_o    = result_q;
  assign Zero_o      = zero_q;

endmodule

// File: tb/tb_alu_iterative_exec.sv
// tb/tb_alu_iterative_exec.sv - self-checking bench for alu_iterative_exec
module tb_alu_iterative_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  ctrl;
  logic [31:0] a, b;
  logic        flush;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          hold;
  } vec_t;

  vec_t tbl[8];

  alu_iterative_exec #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .ALUCtrl_i   (ctrl),
    .A_i         (a),
    .B_i         (b),
    .flush_i     (flush),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .Result_o    (result),
    .Zero_o      (zero),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: RV32 ALU semantics in plain arithmetic
  function automatic void model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output int lat);
    int sh;
    sh  = int'(y[4:0]);
    lat = 1;
    case (c)
      4'd1: r = x - y;
      4'd2: begin r = x << sh; lat = 1 + sh; end
      4'd3: r = x ^ y;
      4'd4: begin r = x >> sh; lat = 1 + sh; end
      4'd5: begin r = 32'($signed(x) >>> sh); lat = 1 + sh; end
      4'd6: r = x | y;
      4'd7: r = x & y;
      4'd8: begin r = y << 12; lat = 13; end
      default: r = x + y;
    endcase
  endfunction

  task automatic do_op(input string name, input logic [3:0] c, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input int exp_lat,
                       input int hold);
    int lat;
    logic [31:0] held;
    lat = 0;
    @(negedge clk);
    res_ready = (hold == 0);
    ctrl = c; a = x; b = y; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    a = $urandom; b = $urandom; ctrl = 4'($urandom_range(0, 15));
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (res_valid) lat = i;
    end
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " result"}, result, exp);
    chk({name, " zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, " hold valid"}, {31'd0, res_valid}, 32'd1);
      chk({name, " hold result"}, result, held);
      chk({name, " hold req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk({name, " ready after handshake"}, {31'd0, req_ready}, 32'd1);
    chk({name, " valid after handshake"}, {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int          l;

    tbl[0] = '{4'b0001, 32'd5,         32'd5,         32'h00000000, 1,  0};
    tbl[1] = '{4'b0000, 32'hFFFFFFFF,  32'd1,         32'h00000000, 1,  0};
    tbl[2] = '{4'b0011, 32'hF0F0F0F0,  32'hFFFF0000,  32'h0F0FF0F0, 1,  0};
    tbl[3] = '{4'b0101, 32'h80000000,  32'd31,        32'hFFFFFFFF, 32, 0};
    tbl[4] = '{4'b0100, 32'h80000000,  32'd31,        32'h00000001, 32, 0};
    tbl[5] = '{4'b0010, 32'd1,         32'd0,         32'h00000001, 1,  0};
    tbl[6] = '{4'b1000, 32'h12345678,  32'h000ABCDE,  32'hABCDE000, 13, 5};
    tbl[7] = '{4'b1011, 32'd3,         32'd4,         32'h00000007, 1,  0};

    rst_n = 1'b0; req_valid = 1'b0; ctrl = '0; a = '0; b = '0;
    flush = 1'b0; res_ready = 1'b1;
    #12;
    chk("reset valid", {31'd0, res_valid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset zero", {31'd0, zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 8; i++)
      do_op($sformatf("vec%0d", i), tbl[i].ctrl, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, tbl[i].hold);

    // Flush on the 5th SHIFT cycle of sll 1<<20, alongside a competing request
    @(negedge clk);
    ctrl = 4'b0010; a = 32'd1; b = 32'd20; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("flush busy before", {31'd0, busy}, 32'd1);
    flush = 1'b1; req_valid = 1'b1; ctrl = 4'b0000; a = 32'd7; b = 32'd8;
    @(posedge clk);
    #1 flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush req_ready", {31'd0, req_ready}, 32'd1);
    chk("flush result kept", result, 32'd16);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush no valid", {31'd0, res_valid}, 32'd0);
    end
    do_op("add after flush", 4'b0000, 32'd100, 32'd23, 32'd123, 1, 0);

    // Asynchronous reset in the middle of srl
    @(negedge clk);
    ctrl = 4'b0100; a = 32'hFFFF0000; b = 32'd8; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid-shift busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset valid", {31'd0, res_valid}, 32'd0);
    chk("async reset busy", {31'd0, busy}, 32'd0);
    chk("async reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after reset req_ready", {31'd0, req_ready}, 32'd1);

    // Randomized operations against the reference model
    for (int i = 0; i < 80; i++) begin
      logic [3:0]  c;
      logic [31:0] x, y;
      c = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      if (i % 4 == 0) x = 32'd0;
      model(c, x, y, r, l);
      do_op($sformatf("rand%0d op%0d", i, c), c, x, y, r, l, i % 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
